// File: rtl/if_id_stage.sv
// IF/ID pipeline register with a 2-entry skid buffer; if_ready_o is a pure flop output.
// Optional `IFID_STALL_CNT_EN adds stall_cnt_o counting fetch-side stall cycles.
module if_id_stage #(
    parameter int unsigned PC_W      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            if_valid_i,
    output logic            if_ready_o,
    input  logic [PC_W-1:0] if_pc_i,
    input  logic [31:0]     if_instr_i,
    output logic            id_valid_o,
    input  logic            id_ready_i,
    output logic [PC_W-1:0] id_pc_o,
    output logic [PC_W-1:0] id_pc4_o,
    output logic [31:0]     id_instr_o,
    output logic [5:0]      id_opcode_o,
    output logic [4:0]      id_rs_o,
    output logic [4:0]      id_rt_o,
    output logic [4:0]      id_rd_o,
    output logic [4:0]      id_shamt_o,
    output logic [5:0]      id_funct_o,
    output logic [15:0]     id_imm_o
`ifdef IFID_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            if_ready_q, if_ready_d;
    logic [PC_W-1:0] main_pc_q, main_pc_d;
    logic [31:0]     main_instr_q, main_instr_d;
    logic [PC_W-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            in_xfer;
    logic            out_xfer;

    assign id_valid_o = (state_q != EMPTY);
    assign in_xfer    = if_valid_i & if_ready_q;
    assign out_xfer   = id_valid_o & id_ready_i;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_xfer) begin
                        state_d      = ONE;
                        main_pc_d    = if_pc_i;
                        main_instr_d = if_instr_i;
                    end
                end
                ONE: begin
                    if (in_xfer && out_xfer) begin
                        main_pc_d    = if_pc_i;
                        main_instr_d = if_instr_i;
                    end else if (out_xfer) begin
                        state_d = EMPTY;
                    end else if (in_xfer) begin
                        state_d      = TWO;
                        skid_pc_d    = if_pc_i;
                        skid_instr_d = if_instr_i;
                    end
                end
                TWO: begin
                    // if_ready_q is low here, so only a drain can happen
                    if (out_xfer) begin
                        state_d      = ONE;
                        main_pc_d    = skid_pc_q;
                        main_instr_d = skid_instr_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        if_ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= EMPTY;
            if_ready_q   <= 1'b1;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            if_ready_q   <= if_ready_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

`ifdef IFID_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (if_valid_i && !if_ready_q) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

    assign if_ready_o  = if_ready_q;
    assign id_pc_o     = main_pc_q;
    assign id_pc4_o    = main_pc_q + PC_W'(4);
    assign id_instr_o  = id_valid_o ? main_instr_q : NOP_INSTR;
    assign id_opcode_o = id_instr_o[31:26];
    assign id_rs_o     = id_instr_o[25:21];
    assign id_rt_o     = id_instr_o[20:16];
    assign id_rd_o     = id_instr_o[15:11];
    assign id_shamt_o  = id_instr_o[10:6];
    assign id_funct_o  = id_instr_o[5:0];
    assign id_imm_o    = id_instr_o[15:0];

endmodule
